// File: rtl/gc_poll_tx.sv
// gc_poll_tx: console-side transmitter for the GameCube single-wire protocol.
// It sends the 24-bit poll command {0x40, 0x03, 7'b0, rumble} MSB first and then a
// stop bit on an open-drain line. After that it raises GC_enable for a fixed
// listening window so the response reader can own the line.
// Optional build macro: GC_AUTO_POLL_EN adds a free-running auto-poll trigger
// that fires after POLL_INTERVAL_US microseconds spent idle.
// All outputs come straight from flops. Frame acceptance takes one cycle, so the
// line goes low on the edge after the one that samples start.
module gc_poll_tx #(
    parameter int US_TICKS         = 48,
    parameter int RESP_US          = 400,
    parameter int POLL_INTERVAL_US = 8000
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic rumble,
    output logic drive_low,
    output logic GC_enable,
    output logic busy,
    output logic done
);

    localparam int LONG_CYC   = 3 * US_TICKS;
    localparam int LISTEN_CYC = RESP_US * US_TICKS;
    localparam int TMR_MAX    = (LONG_CYC > LISTEN_CYC) ? LONG_CYC : LISTEN_CYC;
    localparam int TMR_W      = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] T_ONE    = TMR_W'(1);
    localparam logic [TMR_W-1:0] T_SHORT  = TMR_W'(US_TICKS);
    localparam logic [TMR_W-1:0] T_LONG   = TMR_W'(LONG_CYC);
    localparam logic [TMR_W-1:0] T_LISTEN = TMR_W'(LISTEN_CYC);
    localparam logic [4:0]       LAST_BIT = 5'd23;

    // Reject parameter sets that cannot produce a valid waveform.
    if (US_TICKS < 2) begin : g_bad_us_ticks
        $error("gc_poll_tx: US_TICKS must be at least 2");
    end
    if (RESP_US < 1) begin : g_bad_resp_us
        $error("gc_poll_tx: RESP_US must be at least 1");
    end
    if (POLL_INTERVAL_US < 1) begin : g_bad_poll_interval
        $error("gc_poll_tx: POLL_INTERVAL_US must be at least 1");
    end

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        BIT_LOW  = 3'd1,
        BIT_HIGH = 3'd2,
        STOP_LOW = 3'd3,
        LISTEN   = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [23:0]       shreg_q, shreg_d;
    logic [4:0]        bitcnt_q, bitcnt_d;
    logic              accept_q, accept_d;
    logic              drive_low_q, drive_low_d;
    logic              gc_enable_q, gc_enable_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic              timer_expire;
    logic              auto_fire;
    logic              go;

    assign timer_expire = (timer_q == T_ONE);

    // A frame is accepted only from a settled IDLE. The accept_q cycle sits between
    // acceptance and the first low phase, and it blocks a second trigger there.
    assign go = (start || auto_fire) && (state_q == IDLE) && !accept_q;

`ifdef GC_AUTO_POLL_EN
    localparam int POLL_CYC = POLL_INTERVAL_US * US_TICKS;
    localparam int IVL_W    = (POLL_CYC > 1) ? $clog2(POLL_CYC) : 1;
    localparam logic [IVL_W-1:0] IVL_LAST = IVL_W'(POLL_CYC - 1);

    logic [IVL_W-1:0] ivl_q, ivl_d;

    assign auto_fire = (state_q == IDLE) && !accept_q && (ivl_q == IVL_LAST);

    // Interval counter advances only while idle; any frame activity restarts it at 0.
    always_comb begin
        if ((state_q != IDLE) || accept_q || go) begin
            ivl_d = '0;
        end else begin
            ivl_d = ivl_q + IVL_W'(1);
        end
    end

    // Interval counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ivl_q <= '0;
        end else begin
            ivl_q <= ivl_d;
        end
    end
`else
    assign auto_fire = 1'b0;
`endif

    // State, timer, counters and registered outputs. The shift register holds
    // payload only, so it is not reset: it is always loaded before it is used.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            bitcnt_q    <= '0;
            accept_q    <= 1'b0;
            drive_low_q <= 1'b0;
            gc_enable_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            bitcnt_q    <= bitcnt_d;
            accept_q    <= accept_d;
            drive_low_q <= drive_low_d;
            gc_enable_q <= gc_enable_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
        shreg_q <= shreg_d;
    end

    // Next-state logic. Each phase loads its length into the timer on entry and
    // leaves when the timer reads 1.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        accept_d = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (accept_q) begin
                    // A 1 bit is a short low phase; a 0 bit is a long one.
                    state_d = BIT_LOW;
                    timer_d = shreg_q[23] ? T_SHORT : T_LONG;
                end else if (go) begin
                    accept_d = 1'b1;
                    shreg_d  = {8'h40, 8'h03, 7'b0, rumble};
                    bitcnt_d = '0;
                end
            end

            BIT_LOW: begin
                if (timer_expire) begin
                    // The high phase fills the rest of the 4 us bit cell.
                    state_d = BIT_HIGH;
                    timer_d = shreg_q[23] ? T_LONG : T_SHORT;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end

            BIT_HIGH: begin
                if (timer_expire) begin
                    shreg_d = {shreg_q[22:0], 1'b0};
                    if (bitcnt_q == LAST_BIT) begin
                        state_d  = STOP_LOW;
                        timer_d  = T_SHORT;
                        bitcnt_d = '0;
                    end else begin
                        // The next MSB is already sitting at bit 22.
                        state_d  = BIT_LOW;
                        timer_d  = shreg_q[22] ? T_SHORT : T_LONG;
                        bitcnt_d = bitcnt_q + 5'd1;
                    end
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end

            STOP_LOW: begin
                if (timer_expire) begin
                    state_d = LISTEN;
                    timer_d = T_LISTEN;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end

            LISTEN: begin
                if (timer_expire) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q - T_ONE;
                end
            end

            default: begin
                state_d  = IDLE;
                timer_d  = '0;
                bitcnt_d = '0;
            end
        endcase
    end

    // Output decode from the next state, so the output flops change on the same
    // edge as the state and never glitch.
    always_comb begin
        drive_low_d = (state_d == BIT_LOW) || (state_d == STOP_LOW);
        gc_enable_d = (state_d == LISTEN);
        busy_d      = (state_d != IDLE);
        done_d      = (state_q == LISTEN) && (state_d == IDLE);
    end

    assign drive_low = drive_low_q;
    assign GC_enable = gc_enable_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_gc_poll_tx.sv
// tb_gc_poll_tx: directed bench for gc_poll_tx with US_TICKS=4 and RESP_US=10.
// A frame-offset model predicts every output on every cycle. Literal checks on
// captured frames pin that model to hand-computed numbers.
`timescale 1ns/1ps
module tb_gc_poll_tx;

    localparam int U        = 4;
    localparam int RESP     = 10;
`ifdef GC_AUTO_POLL_EN
    localparam int POLL     = 200;
`else
    localparam int POLL     = 8000;
`endif
    localparam int BITP     = 4 * U;                 // 16 cycles per bit cell
    localparam int STOP_END = 97 * U;                // last stop-low offset: 388
    localparam int DONE_OFF = 1 + 97 * U + RESP * U; // done offset: 429
    localparam int CAP      = 440;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start = 1'b0;
    logic rumble = 1'b0;
    logic drive_low, gc_en, busy, done;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    gc_poll_tx #(
        .US_TICKS(U),
        .RESP_US(RESP),
        .POLL_INTERVAL_US(POLL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .start(start),
        .rumble(rumble),
        .drive_low(drive_low),
        .GC_enable(gc_en),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // A frame is described by its accept edge and its 24-bit word. Each output
    // is a function of the offset from that edge.
    bit          have_frame = 1'b0;
    bit          seen_reset = 1'b0;
    int          f_start = 0;
    int          rst_edge = 0;
    logic [23:0] f_word = '0;
    bit          m_idle, m_fire;
    int          m_ref, off, e_dl, e_bz, e_ge, e_dn;

    function automatic int exp_drive(input int o, input logic [23:0] w);
        int k, pos, low;
        if (o >= 1 && o <= 96 * U) begin
            k   = (o - 1) / BITP;
            pos = (o - 1) % BITP;
            low = w[23 - k] ? U : 3 * U;
            return (pos < low) ? 1 : 0;
        end
        if (o > 96 * U && o <= STOP_END) return 1;
        return 0;
    endfunction

    always begin
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            have_frame = 1'b0;
            rst_edge   = cyc;
            seen_reset = 1'b1;
        end else if (seen_reset) begin
            m_idle = !have_frame || (cyc - f_start > DONE_OFF);
            m_fire = start;
`ifdef GC_AUTO_POLL_EN
            m_ref = have_frame ? f_start + DONE_OFF : rst_edge;
            if (cyc - m_ref == POLL * U) m_fire = 1'b1;
`endif
            if (m_idle && m_fire) begin
                have_frame = 1'b1;
                f_start    = cyc;
                f_word     = {16'h4003, 7'b0, rumble};
            end
        end
        if (seen_reset) begin
            off  = cyc - f_start;
            e_dl = have_frame ? exp_drive(off, f_word) : 0;
            e_bz = (have_frame && off >= 1 && off < DONE_OFF) ? 1 : 0;
            e_ge = (have_frame && off > STOP_END && off < DONE_OFF) ? 1 : 0;
            e_dn = (have_frame && off == DONE_OFF) ? 1 : 0;
            chk($sformatf("drive_low@%0d", cyc), int'(drive_low), e_dl);
            chk($sformatf("busy@%0d", cyc), int'(busy), e_bz);
            chk($sformatf("GC_enable@%0d", cyc), int'(gc_en), e_ge);
            chk($sformatf("done@%0d", cyc), int'(done), e_dn);
        end
    end

    // ---------------- capture and directed stimulus ----------------
    logic dl [0:CAP];
    logic bz [0:CAP];
    logic ge [0:CAP];
    logic dn [0:CAP];

    // Index i holds the outputs after edge S+i, where S is the edge that samples start.
    task automatic run_frame(input logic rum, input int tog, input int s1, input int s2,
                             input int s3, input int rst_at);
        rumble = rum;
        start  = 1'b1;
        for (int i = 0; i <= CAP; i++) begin
            @(negedge clk);
            dl[i] = drive_low;
            bz[i] = busy;
            ge[i] = gc_en;
            dn[i] = done;
            start = (i + 1 == s1) || (i + 1 == s2) || (i + 1 == s3);
            reset = (i + 1 == rst_at);
            if (i == tog) rumble = ~rumble;
        end
        start  = 1'b0;
        reset  = 1'b0;
        rumble = 1'b0;
    endtask

    function automatic int low_cnt(input int b);
        int n = 0;
        for (int j = 0; j < BITP; j++) n += int'(dl[1 + b * BITP + j]);
        return n;
    endfunction

    function automatic int decode_word();
        logic [23:0] w = '0;
        for (int b = 0; b < 24; b++) w[23 - b] = (low_cnt(b) <= U);
        return int'(w);
    endfunction

    initial begin
        int first_ge, last_ge, dl_win, first_dn, stop_low, auto_at;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_drive_low", int'(drive_low), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_GC_enable", int'(gc_en), 0);
        chk("reset_done", int'(done), 0);

        // Frame shape, listening window and busy rejection (starts at 50 and 429 ignored, 430 taken).
        run_frame(1'b0, -1, 50, DONE_OFF, DONE_OFF + 1, -1);
        chk("f1_word", decode_word(), 'h400300);
        chk("f1_bit0_low", low_cnt(0), 12);
        chk("f1_bit1_low", low_cnt(1), 4);
        stop_low = 0;
        for (int i = 385; i <= 392; i++) stop_low += int'(dl[i]);
        chk("f1_stop_low", stop_low, 4);
        first_ge = -1; last_ge = -1; dl_win = 0; first_dn = -1;
        for (int i = 0; i <= DONE_OFF; i++) begin
            if (ge[i] && first_ge < 0) first_ge = i;
            if (ge[i]) last_ge = i;
            if (ge[i] && dl[i]) dl_win++;
            if (dn[i] && first_dn < 0) first_dn = i;
        end
        chk("f1_ge_first", first_ge, 389);
        chk("f1_ge_last", last_ge, 428);
        chk("f1_dl_in_window", dl_win, 0);
        chk("f1_done_at", first_dn, 429);
        chk("f1_busy_before_done", int'(bz[428]), 1);
        chk("f1_busy_at_done", int'(bz[429]), 0);
        chk("f1_no_tx_in_done", int'(dl[430]), 0);
        chk("f1_next_accepted", int'(dl[431]), 1);
        repeat (CAP) @(negedge clk);

        // Rumble bit, with a toggle mid-frame that must be ignored.
        run_frame(1'b1, 100, -1, -1, -1, -1);
        chk("f2_word", decode_word(), 'h400301);
        chk("f2_bit23_low", low_cnt(23), 4);
        repeat (5) @(negedge clk);

        // Reset mid-frame, then a clean frame.
        run_frame(1'b0, -1, -1, -1, -1, 100);
        chk("rst_mid_drive_low", int'(dl[100]), 0);
        chk("rst_mid_busy", int'(bz[100]), 0);
        chk("rst_mid_GC_enable", int'(ge[100]), 0);
        repeat (5) @(negedge clk);
        run_frame(1'b0, -1, -1, -1, -1, -1);
        chk("f4_word", decode_word(), 'h400300);

`ifdef GC_AUTO_POLL_EN
        // No start: the next frame must begin 801 edges after the done edge.
        auto_at = -1;
        for (int j = CAP + 1; j <= CAP + 1000; j++) begin
            @(negedge clk);
            if (busy && auto_at < 0) auto_at = j;
        end
        chk("auto_start_offset", auto_at - DONE_OFF, 801);
`else
        auto_at = 0;
        repeat (300) @(negedge clk);
`endif

        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/gc_poll_tx.md
# gc_poll_tx

Console-side transmitter for the GameCube controller single-wire protocol. It serialises the 24-bit poll command (0x40, 0x03, rumble byte) plus stop bit onto the open-drain data line. It then hands the line to the controller-response reader by asserting `GC_enable` for a fixed listening window. It is the initiator for the same line the response reader samples as `POLL`.

## Interface
Parameters:
- `US_TICKS`, default 48: clock cycles per microsecond. Minimum 2.
- `RESP_US`, default 400: listening window length in µs, counted after the stop bit.
- `POLL_INTERVAL_US`, default 8000: auto-poll period in µs. Used only with `GC_AUTO_POLL_EN`.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high reset.
- `start` input 1: single-cycle request to send one poll frame.
- `rumble` input 1: rumble request, placed in bit 0 of the third command byte.
- `drive_low` output 1: open-drain enable. 1 pulls the data line low; 0 releases it.
- `GC_enable` output 1: enables the response reader for the listening window.
- `busy` output 1: high from frame acceptance until `done`.
- `done` output 1: one-cycle pulse at the end of the listening window.

## Operation
States: IDLE, BIT_LOW, BIT_HIGH, STOP_LOW, LISTEN.

- **IDLE**
  - All outputs are 0.
  - When `start` is 1, or an auto-poll trigger fires:
    - load the 24-bit shift register with {8'h40, 8'h03, 7'b0, `rumble`};
    - clear the bit counter (5 bits, 0..23);
    - go to BIT_LOW.
- **BIT_LOW**
  - `drive_low`=1 for L cycles: L = 3·`US_TICKS` if the current MSB is 0, or `US_TICKS` if it is 1.
  - Then go to BIT_HIGH.
- **BIT_HIGH**
  - `drive_low`=0 for 4·`US_TICKS` − L cycles.
  - Then shift left by one and increment the bit counter.
  - If the bit counter was 23, go to STOP_LOW; otherwise go to BIT_LOW.
- **STOP_LOW**
  - `drive_low`=1 for `US_TICKS` cycles, then go to LISTEN.
- **LISTEN**
  - `drive_low`=0 and `GC_enable`=1 for `RESP_US`·`US_TICKS` cycles.
  - Then go to IDLE, with `done`=1 for the single transition cycle.
- `busy` is 1 in every state except IDLE.
- Bits are sent MSB first.
- `rumble` is sampled only at frame acceptance; changes mid-frame are ignored.
- `start` is ignored while `busy` is 1. It is not queued.
- Phase timer width: ceil(log2(max(3·`US_TICKS`, `RESP_US`·`US_TICKS`)+1)) bits, counting down to 1. No wrap-around.
- Reset, including mid-frame: next edge gives state IDLE, all outputs 0, counters 0, and the line is released immediately.

## Timing
- `start` is sampled at edge N. From edge N+1: `drive_low`=1 and `busy`=1.
- Frame length is 97·`US_TICKS` cycles: 96 for the bits plus `US_TICKS` for the stop bit.
- `GC_enable` rises at edge N+1+97·`US_TICKS` and stays high for `RESP_US`·`US_TICKS` cycles.
- `done`=1, `busy`=0 and `GC_enable`=0 all occur on the same edge, which ends LISTEN.
- `start` asserted in the same cycle as `done`: ignored. Acceptance requires IDLE at the sampling edge, so the earliest next frame is one cycle after `done`.
- `drive_low` is a registered output, glitch-free, and changes only on phase boundaries.

## Configuration
- `GC_AUTO_POLL_EN` **defined**:
  - An interval counter runs in IDLE. It is cleared on entry to IDLE and counts up by 1 per cycle.
  - When it reaches `POLL_INTERVAL_US`·`US_TICKS` − 1, it generates an internal start.
  - Explicit `start` still works; the first of the two to arrive wins.
  - Reset clears the interval counter.
- `GC_AUTO_POLL_EN` **undefined**:
  - Frames are sent only on `start`.
  - No interval counter is synthesised.
  - `POLL_INTERVAL_US` is unused.

## Test plan
All scenarios use `US_TICKS`=4 and `RESP_US`=10.
1. **Frame shape.** `start` pulse at cycle 0, `rumble`=0.
   - `drive_low` low-time sequence: bit0 12 low/4 high (0), bit1 4 low/12 high (1).
   - Full pattern decodes to 0x400300.
   - Stop low lasts 4 cycles.
2. **Rumble bit.** `start` with `rumble`=1, then toggle `rumble` mid-frame.
   - Bit 23 is sent as a 1 (4 low/12 high).
   - The mid-frame toggle has no effect.
3. **Listening window.**
   - `GC_enable` is high from cycle 389 through cycle 428.
   - `done` and `busy` fall at cycle 429.
   - `drive_low` stays 0 throughout the window.
4. **Busy rejection.** A second `start` at cycle 50, and another in the `done` cycle: no retransmission. A `start` one cycle after `done` is accepted.
5. **Reset mid-frame.** `reset` at cycle 100.
   - Next edge: `drive_low`=0, `busy`=0, `GC_enable`=0.
   - A following `start` produces a full correct frame.
6. **Auto poll.** With `GC_AUTO_POLL_EN` and `POLL_INTERVAL_US`=200, no `start`: frames begin every 800 cycles after each return to IDLE.
